// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequencer/arbiter for the core's single memory port. Instruction fetch
//   (address = PC) and data load/store (address = ALU result) share the port;
//   one access is granted at a time and the request, write data and the
//   datapath mux select are held stable until memory completes. When both
//   requesters contend, the one that did not win last time is served, so
//   neither can starve the other.
//
// Build option:
//   MEM_ARB_TIMEOUT_EN - when defined, an access waiting TIMEOUT cycles on
//                        mem_ready is aborted, the requester gets rvalid with
//                        zero data and the sticky err flag is raised. When
//                        undefined, accesses wait indefinitely and err is 0.
//
// Parameters:
//   AW       address width
//   DW       data width
//   TIMEOUT  max cycles waiting on mem_ready (timeout build only), >= 2
//
// Ports:
//   clk, rst                      clock (rising edge), async active-low reset
//   if_req, if_addr               fetch request / PC
//   if_gnt, if_rvalid, if_rdata   fetch accept pulse, data-valid pulse, data
//   d_req, d_we, d_be, d_addr,
//   d_wdata                       data request
//   d_gnt, d_rvalid, d_rdata      data accept pulse, read-valid/write-ack, data
//   mem_req, mem_we, mem_be,
//   mem_addr, mem_wdata           memory request
//   mem_ready, mem_rdata          memory completion (sampled while mem_req=1)
//   mem_sel                       datapath address mux: 0 = PC, 1 = ALU
//   busy                          an access is outstanding
//   err                           sticky timeout flag
module mem_access_ctrl #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_sel,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  if (TIMEOUT < 2) begin : g_timeout_range
    $error("mem_access_ctrl: TIMEOUT must be at least 2");
  end

  state_t        state, state_n;
  logic          last_data, last_data_n;
  logic          pick_data, pick_fetch;

  logic          if_gnt_n, if_rvalid_n, d_gnt_n, d_rvalid_n;
  logic [DW-1:0] if_rdata_n, d_rdata_n;
  logic          mem_req_n, mem_we_n, mem_sel_n, busy_n, err_n;
  logic [3:0]    mem_be_n;
  logic [AW-1:0] mem_addr_n;
  logic [DW-1:0] mem_wdata_n;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] wait_cnt, wait_cnt_n;
`endif

  // Round-robin tie-break: on contention, data wins unless it won last time.
  assign pick_data  = d_req && (!if_req || !last_data);
  assign pick_fetch = if_req && !pick_data;

  always_comb begin
    state_n     = state;
    last_data_n = last_data;
    if_gnt_n    = 1'b0;
    d_gnt_n     = 1'b0;
    if_rvalid_n = 1'b0;
    d_rvalid_n  = 1'b0;
    if_rdata_n  = if_rdata;
    d_rdata_n   = d_rdata;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_be_n    = mem_be;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_sel_n   = mem_sel;
`ifdef MEM_ARB_TIMEOUT_EN
    err_n       = err;
    wait_cnt_n  = wait_cnt;
`else
    err_n       = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (pick_data) begin
          state_n     = DATA;
          last_data_n = 1'b1;
          d_gnt_n     = 1'b1;
          mem_req_n   = 1'b1;
          mem_we_n    = d_we;
          mem_be_n    = d_be;
          mem_addr_n  = d_addr;
          mem_wdata_n = d_wdata;
          mem_sel_n   = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
          wait_cnt_n  = '0;
`endif
        end else if (pick_fetch) begin
          state_n     = FETCH;
          last_data_n = 1'b0;
          if_gnt_n    = 1'b1;
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b0;
          mem_be_n    = 4'hF;
          mem_addr_n  = if_addr;
          mem_wdata_n = '0;
          mem_sel_n   = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
          wait_cnt_n  = '0;
`endif
        end
      end

      FETCH, DATA: begin
        if (mem_ready) begin
          state_n   = IDLE;
          mem_req_n = 1'b0;
          if (state == FETCH) begin
            if_rvalid_n = 1'b1;
            if_rdata_n  = mem_rdata;
          end else begin
            d_rvalid_n = 1'b1;
            // A write acknowledge leaves the last read data visible.
            if (!mem_we) d_rdata_n = mem_rdata;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (wait_cnt == CNT_LAST) begin
          state_n   = IDLE;
          mem_req_n = 1'b0;
          err_n     = 1'b1;
          if (state == FETCH) begin
            if_rvalid_n = 1'b1;
            if_rdata_n  = '0;
          end else begin
            d_rvalid_n = 1'b1;
            d_rdata_n  = '0;
          end
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
`endif
      end

      default: begin
        state_n   = IDLE;
        mem_req_n = 1'b0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_data <= 1'b0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_sel   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      state     <= state_n;
      last_data <= last_data_n;
      if_gnt    <= if_gnt_n;
      if_rvalid <= if_rvalid_n;
      if_rdata  <= if_rdata_n;
      d_gnt     <= d_gnt_n;
      d_rvalid  <= d_rvalid_n;
      d_rdata   <= d_rdata_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_be    <= mem_be_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_sel   <= mem_sel_n;
      busy      <= busy_n;
      err       <= err_n;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt  <= wait_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_sel, busy, err;

  int checks = 0;
  int fails  = 0;

  mem_access_ctrl #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_sel(mem_sel), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_req = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    repeat (3) tick();
    checks++;
    if ({mem_req, mem_we, mem_be, mem_sel, if_gnt, d_gnt, if_rvalid, d_rvalid, busy, err} !== 13'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 0",
               {mem_req, mem_we, mem_be, mem_sel, if_gnt, d_gnt, if_rvalid, d_rvalid, busy, err});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'b0) begin
      fails++;
      $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, if_rdata, d_rdata});
    end
    #3 rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 32'h0000_0010;
    mem_ready = 1; mem_rdata = 32'h0051_0113;
    tick();
    checks++;
    if ({if_gnt, d_gnt, mem_req, mem_sel, mem_we, mem_be, busy, if_rvalid} !== 11'b1_0_1_0_0_1111_1_0) begin
      fails++;
      $display("FAIL fetch_grant: got %b expected 10100111110",
               {if_gnt, d_gnt, mem_req, mem_sel, mem_we, mem_be, busy, if_rvalid});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== {32'h0000_0010, 32'h0}) begin
      fails++;
      $display("FAIL fetch_addr: addr=%h wdata=%h expected 00000010/0", mem_addr, mem_wdata);
    end
    if_req = 0;
    tick();
    checks++;
    if ({if_rvalid, if_gnt, mem_req, if_rdata} !== {3'b100, 32'h0051_0113}) begin
      fails++;
      $display("FAIL fetch_rvalid: rvalid=%b gnt=%b req=%b rdata=%h expected 1/0/0/00510113",
               if_rvalid, if_gnt, mem_req, if_rdata);
    end
    tick();
    checks++;
    if ({if_rvalid, busy} !== 2'b00) begin
      fails++;
      $display("FAIL fetch_done: rvalid=%b busy=%b expected 0/0", if_rvalid, busy);
    end
  endtask

  task automatic test_data_read();
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h0000_0200; d_wdata = 32'h0;
    mem_ready = 1; mem_rdata = 32'h1234_5678;
    tick();
    checks++;
    if ({d_gnt, if_gnt, mem_sel, mem_we, mem_addr} !== {4'b1010, 32'h0000_0200}) begin
      fails++;
      $display("FAIL read_grant: gnt=%b ignt=%b sel=%b we=%b addr=%h expected 1/0/1/0/00000200",
               d_gnt, if_gnt, mem_sel, mem_we, mem_addr);
    end
    d_req = 0;
    tick();
    checks++;
    if ({d_rvalid, d_rdata} !== {1'b1, 32'h1234_5678}) begin
      fails++;
      $display("FAIL read_data: rvalid=%b rdata=%h expected 1/12345678", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_data_write();
    d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h0000_0100; d_wdata = 32'hCAFE_F00D;
    mem_ready = 0; mem_rdata = 32'hDEAD_BEEF;
    tick();
    checks++;
    if ({d_gnt, mem_req, mem_we, mem_be, mem_sel} !== 8'b1_1_1_0011_1) begin
      fails++;
      $display("FAIL write_grant: got %b expected 11100111", {d_gnt, mem_req, mem_we, mem_be, mem_sel});
    end
    d_req = 0; d_we = 0; d_be = 4'h0; d_addr = '0; d_wdata = '0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if ({mem_req, mem_we, mem_be, mem_sel, mem_addr, mem_wdata, d_gnt, d_rvalid} !==
          {7'b1_1_0011_1, 32'h0000_0100, 32'hCAFE_F00D, 2'b00}) begin
        fails++;
        $display("FAIL write_hold%0d: req=%b we=%b be=%h sel=%b addr=%h wdata=%h gnt=%b rvalid=%b",
                 k, mem_req, mem_we, mem_be, mem_sel, mem_addr, mem_wdata, d_gnt, d_rvalid);
      end
    end
    mem_ready = 1;
    tick();
    checks++;
    if ({d_rvalid, mem_req, d_rdata} !== {2'b10, 32'h1234_5678}) begin
      fails++;
      $display("FAIL write_ack: rvalid=%b req=%b rdata=%h expected 1/0/12345678",
               d_rvalid, mem_req, d_rdata);
    end
  endtask

  task automatic test_back_to_back();
    // Last winner was data, so fetch goes first.
    if_req = 1; if_addr = 32'h0000_0020;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h0000_0300;
    mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
    for (int k = 0; k < 8; k++) begin
      logic exp_if, exp_d;
      tick();
      exp_if = (k % 2 == 0) && ((k / 2) % 2 == 0);
      exp_d  = (k % 2 == 0) && ((k / 2) % 2 == 1);
      checks++;
      if ({if_gnt, d_gnt} !== {exp_if, exp_d}) begin
        fails++;
        $display("FAIL alt_gnt%0d: if_gnt=%b d_gnt=%b expected %b/%b", k, if_gnt, d_gnt, exp_if, exp_d);
      end
      if (k % 2 == 0) begin
        checks++;
        if (mem_sel !== exp_d) begin
          fails++;
          $display("FAIL alt_sel%0d: mem_sel=%b expected %b", k, mem_sel, exp_d);
        end
      end
    end
    if_req = 0; d_req = 0;
    checks++;
    if ({d_rvalid, d_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
      fails++;
      $display("FAIL alt_rdata: rvalid=%b rdata=%h expected 1/0badf00d", d_rvalid, d_rdata);
    end
    tick();
  endtask

  task automatic test_idle_ready();
    mem_rdata = 32'h1111_1111;
    for (int k = 0; k < 3; k++) begin
      mem_ready = (k != 1);
      tick();
      checks++;
      if ({if_rvalid, d_rvalid, busy, mem_req, if_gnt, d_gnt, if_rdata, d_rdata} !==
          {6'b0, 32'h0BAD_F00D, 32'h0BAD_F00D}) begin
        fails++;
        $display("FAIL idle_ready%0d: rv=%b/%b busy=%b req=%b rdata=%h/%h",
                 k, if_rvalid, d_rvalid, busy, mem_req, if_rdata, d_rdata);
      end
    end
  endtask

  task automatic test_timeout();
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h0000_0300;
    mem_ready = 0; mem_rdata = 32'h2222_2222;
    tick();
    checks++;
    if ({d_gnt, busy} !== 2'b11) begin
      fails++;
      $display("FAIL stall_grant: d_gnt=%b busy=%b expected 1/1", d_gnt, busy);
    end
    d_req = 0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int k = 1; k <= 15; k++) begin
      tick();
      checks++;
      if ({busy, mem_req, d_rvalid, err} !== 4'b1100) begin
        fails++;
        $display("FAIL tmo_wait%0d: busy/req/rvalid/err=%b expected 1100", k, {busy, mem_req, d_rvalid, err});
      end
    end
    tick();
    checks++;
    if ({busy, mem_req, d_rvalid, err, d_rdata} !== {4'b0011, 32'h0}) begin
      fails++;
      $display("FAIL tmo_abort: busy/req/rvalid/err=%b rdata=%h expected 0011/0",
               {busy, mem_req, d_rvalid, err}, d_rdata);
    end
    repeat (3) tick();
    checks++;
    if ({err, d_rvalid} !== 2'b10) begin
      fails++;
      $display("FAIL tmo_sticky: err=%b rvalid=%b expected 1/0", err, d_rvalid);
    end
`else
    begin
      int bad = 0;
      for (int k = 1; k <= 100; k++) begin
        tick();
        if ({busy, mem_req, d_rvalid, err} !== 4'b1100) bad++;
      end
      checks++;
      if (bad != 0) begin
        fails++;
        $display("FAIL stall_hold: %0d of 100 cycles left busy/req or set rvalid/err, expected 0", bad);
      end
    end
`endif
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({err, busy, mem_req} !== 3'b000) begin
      fails++;
      $display("FAIL stall_reset: err/busy/req=%b expected 000", {err, busy, mem_req});
    end
    tick();
    #3 rst = 1'b1;
  endtask

  task automatic test_reset_mid();
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h0000_0400; d_wdata = 32'h0000_0055;
    mem_ready = 0;
    tick();
    checks++;
    if ({d_gnt, mem_sel, busy} !== 3'b111) begin
      fails++;
      $display("FAIL rmid_grant: gnt/sel/busy=%b expected 111", {d_gnt, mem_sel, busy});
    end
    d_req = 0;
    tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mem_req, busy, mem_sel, d_rvalid, d_gnt} !== 5'b0) begin
      fails++;
      $display("FAIL rmid_reset: req/busy/sel/rvalid/gnt=%b expected 00000",
               {mem_req, busy, mem_sel, d_rvalid, d_gnt});
    end
    tick();
    #3 rst = 1'b1;
    if_req = 1; if_addr = 32'h0000_0044;
    mem_ready = 1; mem_rdata = 32'hA5A5_0001;
    tick();
    checks++;
    if ({if_gnt, d_gnt, mem_sel, mem_req, mem_addr} !== {4'b1001, 32'h0000_0044}) begin
      fails++;
      $display("FAIL rmid_fetch: gnt=%b dgnt=%b sel=%b req=%b addr=%h expected 1/0/0/1/00000044",
               if_gnt, d_gnt, mem_sel, mem_req, mem_addr);
    end
    if_req = 0;
    tick();
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'hA5A5_0001}) begin
      fails++;
      $display("FAIL rmid_rdata: rvalid=%b rdata=%h expected 1/a5a50001", if_rvalid, if_rdata);
    end
    tick();
    checks++;
    if ({busy, if_rvalid} !== 2'b00) begin
      fails++;
      $display("FAIL rmid_done: busy=%b rvalid=%b expected 0/0", busy, if_rvalid);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_data_read();
    test_data_write();
    test_back_to_back();
    test_idle_ready();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
